// File: rtl/tms1000_pkg.sv
// Shared definitions for the TMS1000 panel: pin widths, capture FSM encodings
// and the 7-segment pattern table.
package tms1000_pkg;

  localparam int K_WIDTH = 4;
  localparam int R_WIDTH = 11;
  localparam int O_WIDTH = 8;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_SETTLE = 2'd1;
  localparam logic [1:0] STATE_LATCH  = 2'd2;

  typedef enum logic [1:0] {
    CAP_IDLE   = STATE_IDLE,
    CAP_SETTLE = STATE_SETTLE,
    CAP_LATCH  = STATE_LATCH
  } cap_state_e;

  // Segment order {dp, a, b, c, d, e, f, g}, active high.
  function automatic logic [O_WIDTH-1:0] seg7_pattern(input logic [3:0] digit);
    logic [O_WIDTH-1:0] pat;
    case (digit)
      4'h0:    pat = 8'h7e;
      4'h1:    pat = 8'h30;
      4'h2:    pat = 8'h6d;
      4'h3:    pat = 8'h79;
      4'h4:    pat = 8'h33;
      4'h5:    pat = 8'h5b;
      4'h6:    pat = 8'h5f;
      4'h7:    pat = 8'h70;
      4'h8:    pat = 8'h7f;
      4'h9:    pat = 8'h7b;
      4'ha:    pat = 8'h77;
      4'hb:    pat = 8'h1f;
      4'hc:    pat = 8'h4e;
      4'hd:    pat = 8'h3d;
      4'he:    pat = 8'h4f;
      4'hf:    pat = 8'h47;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/tms1000_key_debounce.sv
// Key matrix debouncer: a free-running sample tick feeds a 2-sample history
// per key; a key changes state only after two agreeing samples.
module tms1000_key_debounce
  import tms1000_pkg::*;
#(
  parameter int WIDTH           = 44,
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic             raw_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys_raw,
  output logic [WIDTH-1:0] key_db
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    sample_cnt_r;
  logic             tick_s;
  logic [WIDTH-1:0] hist_new_r;
  logic [WIDTH-1:0] hist_old_r;
  logic [WIDTH-1:0] key_db_r;

  assign tick_s = (sample_cnt_r == CNT_MAX);
  assign key_db = key_db_r;

  // Sample tick, history shift and set-on-11 / clear-on-00 update.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      sample_cnt_r <= '0;
      hist_new_r   <= '0;
      hist_old_r   <= '0;
      key_db_r     <= '0;
    end else begin
      if (tick_s) begin
        sample_cnt_r <= '0;
        hist_new_r   <= keys_raw;
        hist_old_r   <= hist_new_r;
        // Mixed histories leave the debounced value untouched.
        key_db_r     <= (key_db_r | (hist_new_r & hist_old_r)) & (hist_new_r | hist_old_r);
      end else begin
        sample_cnt_r <= sample_cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tms1000_panel.sv
// Panel-side responder for the TMS1000 R/O/K pins: digit capture, LED refresh
// and K reply. Define TMS1000_PANEL_BLANK_EN to blank digits the CPU stops updating.
module tms1000_panel
  import tms1000_pkg::*;
#(
  parameter int NUM_DIGITS      = 11,
  parameter int SETTLE_CYCLES   = 32,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int REFRESH_CYCLES  = 2048
) (
  input  logic                          raw_clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS-1:0]         pins_r,
  input  logic [O_WIDTH-1:0]            pins_o,
  output logic [K_WIDTH-1:0]            pins_k,
  input  logic [NUM_DIGITS*K_WIDTH-1:0] keys_raw,
  output logic [O_WIDTH-1:0]            seg_n,
  output logic [NUM_DIGITS-1:0]         digit_n
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int FW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [SW-1:0]         SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0]         REFRESH_MAX = FW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_MAX     = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] R_ONE       = NUM_DIGITS'(1'b1);

  logic [NUM_DIGITS-1:0]         r_meta_r;
  logic [NUM_DIGITS-1:0]         r_s;
  logic [O_WIDTH-1:0]            o_meta_r;
  logic [O_WIDTH-1:0]            o_s;
  logic [NUM_DIGITS-1:0]         r_prev_r;
  cap_state_e                    state_r;
  logic [SW-1:0]                 settle_cnt_r;
  logic [O_WIDTH-1:0]            disp_buf_r [NUM_DIGITS];
  logic [FW-1:0]                 refresh_cnt_r;
  logic [IW-1:0]                 scan_idx_r;
  logic [K_WIDTH-1:0]            pins_k_r;
  logic [O_WIDTH-1:0]            seg_n_r;
  logic [NUM_DIGITS-1:0]         digit_n_r;
  logic [NUM_DIGITS*K_WIDTH-1:0] key_db_s;
  logic [IW-1:0]                 wr_idx_s;
  logic [K_WIDTH-1:0]            k_or_s;
  logic                          onehot_s;
  logic                          latch_wr_s;
  logic                          frame_wrap_s;
  logic                          blank_s;

  assign pins_k  = pins_k_r;
  assign seg_n   = seg_n_r;
  assign digit_n = digit_n_r;

  tms1000_key_debounce #(
    .WIDTH           (NUM_DIGITS * K_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .raw_clk  (raw_clk),
    .reset    (reset),
    .keys_raw (keys_raw),
    .key_db   (key_db_s)
  );

  // Two-flop synchronizers for the CPU strobe and segment buses.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_meta_r <= '0;
      r_s      <= '0;
      o_meta_r <= '0;
      o_s      <= '0;
    end else begin
      r_meta_r <= pins_r;
      r_s      <= r_meta_r;
      o_meta_r <= pins_o;
      o_s      <= o_meta_r;
    end
  end

  // Decode the strobe pattern and gather the K reply from every strobed row.
  always_comb begin
    wr_idx_s = '0;
    k_or_s   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      wr_idx_s = wr_idx_s | (IW'(i) & {IW{r_s[i]}});
      k_or_s   = k_or_s | (key_db_s[i*K_WIDTH +: K_WIDTH] & {K_WIDTH{r_s[i]}});
    end
  end

  // The OR-ed index is only meaningful when exactly one strobe is high.
  assign onehot_s     = (r_s != '0) && ((r_s & (r_s - R_ONE)) == '0);
  assign latch_wr_s   = (state_r == CAP_LATCH) && onehot_s;
  assign frame_wrap_s = (refresh_cnt_r == REFRESH_MAX) && (scan_idx_r == IDX_MAX);

  // Capture FSM: wait for R to hold still, then store O into the strobed digit.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_r      <= CAP_IDLE;
      settle_cnt_r <= '0;
      r_prev_r     <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_buf_r[i] <= '0;
      end
    end else begin
      r_prev_r <= r_s;
      case (state_r)
        CAP_IDLE: begin
          if (r_s != r_prev_r) begin
            state_r      <= CAP_SETTLE;
            settle_cnt_r <= SETTLE_LOAD;
          end
        end
        CAP_SETTLE: begin
          if (r_s != r_prev_r) begin
            settle_cnt_r <= SETTLE_LOAD;
          end else if (settle_cnt_r == '0) begin
            state_r <= CAP_LATCH;
          end else begin
            settle_cnt_r <= settle_cnt_r - 1'b1;
          end
        end
        CAP_LATCH: begin
          if (latch_wr_s) begin
            disp_buf_r[wr_idx_s] <= o_s;
          end
          state_r <= CAP_IDLE;
        end
        default: begin
          state_r <= CAP_IDLE;
        end
      endcase
    end
  end

`ifdef TMS1000_PANEL_BLANK_EN
  logic [3:0] stale_r [NUM_DIGITS];

  // Per-digit staleness: cleared by a write, aged once per full scan frame.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        stale_r[i] <= 4'd15;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (latch_wr_s && (wr_idx_s == IW'(i))) begin
          stale_r[i] <= 4'd0;
        end else if (frame_wrap_s && (stale_r[i] != 4'd15)) begin
          stale_r[i] <= stale_r[i] + 4'd1;
        end
      end
    end
  end

  assign blank_s = (stale_r[scan_idx_r] == 4'd15);
`else
  assign blank_s = 1'b0;
`endif

  // Multiplexed refresh plus the registered K reply.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      refresh_cnt_r <= '0;
      scan_idx_r    <= '0;
      seg_n_r       <= 8'hff;
      digit_n_r     <= '1;
      pins_k_r      <= '0;
    end else begin
      if (refresh_cnt_r == REFRESH_MAX) begin
        refresh_cnt_r <= '0;
        scan_idx_r    <= (scan_idx_r == IDX_MAX) ? '0 : scan_idx_r + 1'b1;
      end else begin
        refresh_cnt_r <= refresh_cnt_r + 1'b1;
      end
      digit_n_r <= ~(R_ONE << scan_idx_r);
      seg_n_r   <= blank_s ? 8'hff : ~disp_buf_r[scan_idx_r];
      pins_k_r  <= k_or_s;
    end
  end

endmodule
